// File: rtl/asic_iopocctrl.sv
// ---------------------------------------------------------------------------
// asic_iopocctrl
//
// Power-on-control sequencer for the padring POC net. It synchronizes and
// debounces the IO and core rail good indications. It keeps the pads in the
// safe state (poc=1) until both rails have been stable for DEBOUNCE cycles
// and a further RELEASE_DLY cycles have elapsed. It then releases poc and,
// one cycle later, enables IO. When a rail drops, poc is re-asserted and the
// sticky brownout flag is raised. A force request re-enters the safe state
// without raising brownout.
//
// Ports
//   clk          always-on core clock
//   nreset       asynchronous active-low reset, released synchronously
//   vddio_good   IO rail good (asynchronous)
//   vdd_good     core rail good (asynchronous)
//   force_poc    synchronous request to return to the safe state
//   clr_brownout synchronous clear of the brownout flag
//   poc          1 = pads held safe (registered)
//   io_enable    1 = IO usable from the core side (registered)
//   state        FSM state for debug: 0 DEB, 1 HOLD, 2 RUN
//   brownout     sticky rail-drop flag
// ---------------------------------------------------------------------------
module asic_iopocctrl #(
    parameter int CW          = 16,
    parameter int DEBOUNCE    = 16,
    parameter int RELEASE_DLY = 32
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       vddio_good,
    input  logic       vdd_good,
    input  logic       force_poc,
    input  logic       clr_brownout,
    output logic       poc,
    output logic       io_enable,
    output logic [1:0] state,
    output logic       brownout
);

    typedef enum logic [1:0] {
        ST_DEB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_BAD  = 2'd3
    } st_t;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_DLY - 1);

    st_t            state_q;
    st_t            state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           brown_set;
    logic           brown_d;
    logic           poc_d;
    logic           ioen_d;
    logic           brownout_q;
    logic           poc_q;
    logic           ioen_q;

    // Two-flop synchronizers for the asynchronous rail indications
    logic vddio_sync_p0;
    logic vddio_sync_p1;
    logic vdd_sync_p0;
    logic vdd_sync_p1;
    logic good_s;

    // Saturating increment: the counter holds at all-ones instead of wrapping
    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
        if (c == {CW{1'b1}}) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // ---- stage p0/p1: rail synchronizers ----
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vddio_sync_p0 <= 1'b0;
            vddio_sync_p1 <= 1'b0;
            vdd_sync_p0   <= 1'b0;
            vdd_sync_p1   <= 1'b0;
        end else begin
            vddio_sync_p0 <= vddio_good;
            vddio_sync_p1 <= vddio_sync_p0;
            vdd_sync_p0   <= vdd_good;
            vdd_sync_p1   <= vdd_sync_p0;
        end
    end

    assign good_s = vddio_sync_p1 & vdd_sync_p1;

    // ---- FSM: state, counter and output registers ----
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_DEB;
            cnt_q      <= '0;
            brownout_q <= 1'b0;
            poc_q      <= 1'b1;
            ioen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            brownout_q <= brown_d;
            poc_q      <= poc_d;
            ioen_q     <= ioen_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        brown_set = 1'b0;
        unique case (state_q)
            ST_DEB: begin
                if (!good_s || force_poc) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat_inc(cnt_q);
                end
            end
            ST_HOLD: begin
                if (!good_s || force_poc) begin
                    state_d = ST_DEB;
                    cnt_d   = '0;
                end else if (cnt_q == REL_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat_inc(cnt_q);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // A rail drop takes priority over a force request, so a
                // simultaneous drop is still recorded as a brownout.
                if (!good_s) begin
                    state_d   = ST_DEB;
                    brown_set = 1'b1;
                end else if (force_poc) begin
                    state_d = ST_DEB;
                end
            end
            default: begin
                state_d = ST_DEB;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. poc and io_enable are derived from the next state so that
    // poc drops on the HOLD->RUN edge and rises on the edge that leaves RUN.
    // io_enable needs RUN both now and next. This makes it trail poc by one
    // cycle on release and fall together with poc on exit.
    always_comb begin
        poc_d   = (state_d != ST_RUN);
        ioen_d  = (state_q == ST_RUN) && (state_d == ST_RUN);
        brown_d = brown_set | (brownout_q & ~clr_brownout);
    end

    assign poc       = poc_q;
    assign io_enable = ioen_q;
    assign state     = state_q;
    assign brownout  = brownout_q;

endmodule

// File: tb/tb_asic_iopocctrl.sv
module tb_asic_iopocctrl;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       vddio_good = 1'b0;
    logic       vdd_good = 1'b0;
    logic       force_poc = 1'b0;
    logic       clr_brownout = 1'b0;
    logic       poc;
    logic       io_enable;
    logic [1:0] state;
    logic       brownout;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    int base  = 0;
    int base2 = 0;

    typedef struct {
        int         due;
        logic [4:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    asic_iopocctrl #(.CW(16), .DEBOUNCE(16), .RELEASE_DLY(32)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .vddio_good   (vddio_good),
        .vdd_good     (vdd_good),
        .force_poc    (force_poc),
        .clr_brownout (clr_brownout),
        .poc          (poc),
        .io_enable    (io_enable),
        .state        (state),
        .brownout     (brownout)
    );

    function automatic logic [4:0] ov(input logic p, input logic i,
                                      input logic [1:0] s, input logic b);
        return {p, i, s, b};
    endfunction

    task automatic push(input string tag, input int due, input logic [4:0] e);
        exp_t x;
        x.due = due;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [4:0] obs;
        while (sb.size() > 0 && sb[0].due <= ecnt) begin
            x   = sb.pop_front();
            obs = {poc, io_enable, state, brownout};
            total++;
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s: observed {poc,ioen,state,bo}=%b expected=%b at edge %0d",
                       x.tag, obs, x.exp, ecnt);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ecnt++;
            drain();
        end
    endtask

    // io_enable must never be high while poc is high
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            total++;
            assert (!(io_enable === 1'b1 && poc === 1'b1)) else begin
                bad++;
                $error("FAIL inv_ioen_poc: observed io_enable=%b poc=%b expected not both 1",
                       io_enable, poc);
            end
        end
    end

    initial begin
        // Reset with rails low
        #1 nreset = 1'b0;
        tick(2);
        push("rst_low", ecnt, ov(1, 0, 2'd0, 0));
        drain();
        #2 nreset = 1'b1;
        base = ecnt;
        push("rst_idle1",   base + 1,   ov(1, 0, 2'd0, 0));
        push("rst_idle100", base + 100, ov(1, 0, 2'd0, 0));
        tick(100);

        // Both rails rise: edge 1 is the first edge sampling them high
        vddio_good = 1'b1;
        vdd_good   = 1'b1;
        base = ecnt;
        push("deb_last",    base + 17, ov(1, 0, 2'd0, 0));
        push("hold_entry",  base + 18, ov(1, 0, 2'd1, 0));
        push("pre_release", base + 49, ov(1, 0, 2'd1, 0));
        push("poc_fall",    base + 50, ov(0, 0, 2'd2, 0));
        push("ioen_rise",   base + 51, ov(0, 1, 2'd2, 0));
        tick(52);

        // IO rail drop in RUN -> brownout after synchronizer + 1 edges
        vddio_good = 1'b0;
        base = ecnt;
        push("drop_sync",  base + 2, ov(0, 1, 2'd2, 0));
        push("drop_exit",  base + 3, ov(1, 0, 2'd0, 1));
        push("drop_stay",  base + 5, ov(1, 0, 2'd0, 1));
        tick(5);

        // Restore, then glitch core rail for one cycle at counter=10
        vddio_good = 1'b1;
        base = ecnt;
        push("deb_cnt10", base + 12, ov(1, 0, 2'd0, 1));
        tick(12);
        vdd_good = 1'b0;
        tick(1);
        vdd_good = 1'b1;
        base2 = ecnt;
        push("glitch_restart", base2 + 5,  ov(1, 0, 2'd0, 1));
        push("glitch_hold",    base2 + 49, ov(1, 0, 2'd1, 1));
        push("glitch_fall",    base2 + 50, ov(0, 0, 2'd2, 1));
        push("glitch_ioen",    base2 + 51, ov(0, 1, 2'd2, 1));
        tick(52);

        // Clear brownout
        clr_brownout = 1'b1;
        push("bo_clear", ecnt + 1, ov(0, 1, 2'd2, 0));
        tick(1);
        clr_brownout = 1'b0;

        // Force pulse in RUN: no brownout, full re-sequence without sync delay
        force_poc = 1'b1;
        base = ecnt;
        push("force_exit",   base + 1,  ov(1, 0, 2'd0, 0));
        tick(1);
        force_poc = 1'b0;
        push("force_deb",    base + 16, ov(1, 0, 2'd0, 0));
        push("force_hold",   base + 17, ov(1, 0, 2'd1, 0));
        push("force_hold2",  base + 48, ov(1, 0, 2'd1, 0));
        push("force_fall",   base + 49, ov(0, 0, 2'd2, 0));
        push("force_ioen",   base + 50, ov(0, 1, 2'd2, 0));
        tick(49);

        // Set and clear of brownout in the same cycle: set wins
        vdd_good = 1'b0;
        base = ecnt;
        push("setclr_pre", base + 2, ov(0, 1, 2'd2, 0));
        tick(2);
        clr_brownout = 1'b1;
        push("set_wins", base + 3, ov(1, 0, 2'd0, 1));
        tick(1);
        clr_brownout = 1'b0;
        clr_brownout = 1'b1;
        push("bo_clear2", ecnt + 1, ov(1, 0, 2'd0, 0));
        tick(1);
        clr_brownout = 1'b0;

        // Async reset in the middle of HOLD, between clock edges
        vdd_good = 1'b1;
        base = ecnt;
        push("mid_hold", base + 25, ov(1, 0, 2'd1, 0));
        tick(25);
        #3 nreset = 1'b0;
        #1;
        push("async_rst", ecnt, ov(1, 0, 2'd0, 0));
        drain();
        #2 nreset = 1'b1;

        // force_poc held high keeps the FSM in DEB
        force_poc = 1'b1;
        tick(1);
        push("force_held", ecnt + 80, ov(1, 0, 2'd0, 0));
        tick(80);
        force_poc = 1'b0;

        // Randomized bursty rail toggling; the invariant monitor checks each cycle
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 63) == 0) vddio_good = ~vddio_good;
            if ($urandom_range(0, 63) == 0) vdd_good   = ~vdd_good;
            force_poc    = ($urandom_range(0, 199) == 0);
            clr_brownout = ($urandom_range(0, 49) == 0);
            tick(1);
        end

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_empty: observed %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
